// File: rtl/fsm_prog_seq_alu.sv
// fsm_prog_seq_alu: programmable two-register ALU sequencer with valid/ready operand and result ports.
// Optional build macro FSM_SEQ_SAT_EN: unsigned saturating ADD/SUB/SHL plus a sticky sat_flag output.
module fsm_prog_seq_alu #(
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PROG_LEN*3-1:0] prog,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef FSM_SEQ_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int PC_W = $clog2(PROG_LEN);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, EXEC, WAIT_OUT, FIN} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_SWAP, OP_EMIT, OP_END
  } op_t;

  state_t                state, state_nxt;
  logic [PROG_LEN*3-1:0] prog_q;
  logic [PC_W-1:0]       pc;
  logic [DATA_W-1:0]     reg1, reg2;
  logic                  emit_last;
  logic [2:0]            steps [PROG_LEN];
  op_t                   op;
  logic [DATA_W-1:0]     alu_res, alu_out;

  for (genvar k = 0; k < PROG_LEN; k++) begin : g_step
    assign steps[k] = prog_q[3*k +: 3];
  end

  assign op = op_t'(steps[pc]);

  always_comb begin
    alu_res = reg1;
    case (op)
      OP_ADD:  alu_res = reg1 + reg2;
      OP_SUB:  alu_res = reg1 - reg2;
      OP_SHL:  alu_res = {reg1[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, reg1[DATA_W-1:1]};
      default: alu_res = reg1;
    endcase
  end

`ifdef FSM_SEQ_SAT_EN
  logic alu_sat;

  // Overflow on ADD shows up as a wrapped sum smaller than an operand.
  always_comb begin
    alu_sat = 1'b0;
    alu_out = alu_res;
    case (op)
      OP_ADD: if (alu_res < reg1) begin alu_sat = 1'b1; alu_out = '1; end
      OP_SUB: if (reg1 < reg2)    begin alu_sat = 1'b1; alu_out = '0; end
      OP_SHL: if (reg1[DATA_W-1]) begin alu_sat = 1'b1; alu_out = '1; end
      default: ;
    endcase
  end
`else
  assign alu_out = alu_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD1;
      LOAD1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD2;
      end
      LOAD2: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (op == OP_END)       state_nxt = FIN;
        else if (op == OP_EMIT) state_nxt = WAIT_OUT;
        else if (pc == PC_LAST) state_nxt = FIN;
      end
      WAIT_OUT: if (out_ready) state_nxt = emit_last ? FIN : EXEC;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pc saturates at the last step; emit_last remembers whether an EMIT consumed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_q    <= '0;
      pc        <= '0;
      reg1      <= '0;
      reg2      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      emit_last <= 1'b0;
`ifdef FSM_SEQ_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          prog_q <= prog;
          pc     <= '0;
`ifdef FSM_SEQ_SAT_EN
          sat_flag <= 1'b0;
`endif
        end
        LOAD1: if (in_valid) reg1 <= data_in;
        LOAD2: if (in_valid) reg2 <= data_in;
        EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: reg1 <= alu_out;
            OP_SWAP: begin
              reg1 <= reg2;
              reg2 <= reg1;
            end
            OP_EMIT: begin
              data_out  <= reg1;
              out_valid <= 1'b1;
              emit_last <= (pc == PC_LAST);
            end
            default: ;
          endcase
`ifdef FSM_SEQ_SAT_EN
          if (alu_sat) sat_flag <= 1'b1;
`endif
          if (op != OP_END && pc != PC_LAST) pc <= pc + 1'b1;
        end
        WAIT_OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_prog_seq_alu.sv
// Directed testbench for fsm_prog_seq_alu: 8-step instance for main scenarios, 4-step instance for no-END exit.
module tb_fsm_prog_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] prog = '0;
  logic [7:0]  data_in = '0;
  logic        in_ready, out_valid, busy, done;
  logic [7:0]  data_out;

  logic        start4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic [11:0] prog4 = '0;
  logic [7:0]  data_in4 = '0;
  logic        in_ready4, out_valid4, busy4, done4;
  logic [7:0]  data_out4;
`ifdef FSM_SEQ_SAT_EN
  logic        sat_flag, sat_flag4;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] P_LEGACY = {3'd0, 3'd7, 3'd6, 3'd5, 3'd6, 3'd3, 3'd2, 3'd1};
  localparam logic [23:0] P_ADD_EMIT = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd1};
  localparam logic [23:0] P_SHR = {3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd4, 3'd4};

  fsm_prog_seq_alu #(.DATA_W(8), .PROG_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog(prog), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef FSM_SEQ_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  fsm_prog_seq_alu #(.DATA_W(8), .PROG_LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .prog(prog4), .data_in(data_in4),
    .in_valid(in_valid4), .in_ready(in_ready4), .data_out(data_out4),
    .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4), .done(done4)
`ifdef FSM_SEQ_SAT_EN
    , .sat_flag(sat_flag4)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b exp 0", busy4); end
`ifdef FSM_SEQ_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b exp 0", sat_flag); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_legacy();
    logic       ev, eb, ed, er;
    logic [7:0] edata;
    prog = P_LEGACY; start = 1'b1; in_valid = 1'b1; data_in = 8'h05; out_ready = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) data_in = 8'h03;
      if (k == 3) in_valid = 1'b0;
      ev = (k == 7) || (k == 10);
      eb = (k <= 12);
      ed = (k == 12);
      er = (k == 1) || (k == 2);
      edata = (k < 7) ? 8'h00 : ((k < 10) ? 8'h0A : 8'h03);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL legacy_out_valid k=%0d got %b exp %b", k, out_valid, ev); end
      checks++; if (data_out !== edata) begin errors++; $display("FAIL legacy_data_out k=%0d got %h exp %h", k, data_out, edata); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL legacy_busy k=%0d got %b exp %b", k, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("FAIL legacy_done k=%0d got %b exp %b", k, done, ed); end
      checks++; if (in_ready !== er) begin errors++; $display("FAIL legacy_in_ready k=%0d got %b exp %b", k, in_ready, er); end
    end
`ifdef FSM_SEQ_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL legacy_sat_flag got %b exp 0", sat_flag); end
`endif
  endtask

  task automatic test_backpressure();
    logic       ev, eb, ed;
    logic [7:0] edata;
    prog = P_LEGACY; start = 1'b1; in_valid = 1'b1; data_in = 8'h05; out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) data_in = 8'h03;
      if (k == 3) in_valid = 1'b0;
      ev = (k >= 7 && k <= 11) || (k == 14);
      eb = (k <= 16);
      ed = (k == 16);
      edata = (k < 7) ? 8'h03 : ((k < 14) ? 8'h0A : 8'h03);
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL bp_out_valid k=%0d got %b exp %b", k, out_valid, ev); end
      checks++; if (data_out !== edata) begin errors++; $display("FAIL bp_data_out k=%0d got %h exp %h", k, data_out, edata); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL bp_busy k=%0d got %b exp %b", k, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("FAIL bp_done k=%0d got %b exp %b", k, done, ed); end
      if (k >= 8 && k <= 11) begin
        checks++; if (dut.reg1 !== 8'h0A || dut.reg2 !== 8'h03) begin
          errors++; $display("FAIL bp_regs_frozen k=%0d got %h/%h exp 0a/03", k, dut.reg1, dut.reg2);
        end
      end
      if (k == 11) out_ready = 1'b1;
    end
  endtask

  task automatic test_input_stall();
    prog = P_ADD_EMIT; start = 1'b1; in_valid = 1'b1; data_in = 8'h21; out_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready k=2 got %b exp 1", in_ready); end
        in_valid = 1'b0; data_in = 8'h77;
      end
      if (k >= 3 && k <= 5) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready k=%0d got %b exp 1", k, in_ready); end
        checks++; if (dut.reg2 !== 8'h0A) begin errors++; $display("FAIL stall_reg2_hold k=%0d got %h exp 0a", k, dut.reg2); end
        checks++; if (dut.reg1 !== 8'h21) begin errors++; $display("FAIL stall_reg1 k=%0d got %h exp 21", k, dut.reg1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy k=%0d got %b exp 1", k, busy); end
      end
      if (k == 5) begin in_valid = 1'b1; data_in = 8'h44; end
      if (k == 6) begin
        checks++; if (dut.reg2 !== 8'h44) begin errors++; $display("FAIL stall_reg2_capture got %h exp 44", dut.reg2); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_exec got %b exp 0", in_ready); end
        in_valid = 1'b0;
      end
      if (k == 7) begin
        checks++; if (dut.reg1 !== 8'h65) begin errors++; $display("FAIL stall_add got %h exp 65", dut.reg1); end
      end
      if (k == 8) begin
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h65) begin
          errors++; $display("FAIL stall_emit got %b/%h exp 1/65", out_valid, data_out);
        end
      end
      if (k == 10) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", done); end
      end
      if (k == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", busy); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_emit;
`ifdef FSM_SEQ_SAT_EN
    exp_emit = 8'hFF;
`else
    exp_emit = 8'h01;
`endif
    prog = P_ADD_EMIT; start = 1'b1; in_valid = 1'b1; data_in = 8'hFF; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) data_in = 8'h02;
      if (k == 3) in_valid = 1'b0;
      if (k == 5) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_out_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== exp_emit) begin errors++; $display("FAIL wrap_data_out got %h exp %h", data_out, exp_emit); end
`ifdef FSM_SEQ_SAT_EN
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL wrap_sat_flag got %b exp 1", sat_flag); end
`endif
      end
      if (k == 7) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", done); end
      end
      if (k == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle got %b exp 0", busy); end
`ifdef FSM_SEQ_SAT_EN
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL wrap_sat_sticky got %b exp 1", sat_flag); end
`endif
      end
    end
  endtask

  task automatic test_no_end();
    logic eb, ed;
    prog4 = {3'd1, 3'd1, 3'd1, 3'd1}; start4 = 1'b1; in_valid4 = 1'b1; data_in4 = 8'h10;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) start4 = 1'b0;
      if (k == 2) data_in4 = 8'h01;
      if (k == 3) in_valid4 = 1'b0;
      eb = (k <= 7) || (k == 9);
      ed = (k == 7);
      checks++; if (busy4 !== eb) begin errors++; $display("FAIL noend_busy k=%0d got %b exp %b", k, busy4, eb); end
      checks++; if (done4 !== ed) begin errors++; $display("FAIL noend_done k=%0d got %b exp %b", k, done4, ed); end
      if (k == 7) begin
        checks++; if (dut4.reg1 !== 8'h14) begin errors++; $display("FAIL noend_reg1 got %h exp 14", dut4.reg1); end
        checks++; if (out_valid4 !== 1'b0 || data_out4 !== 8'h00) begin
          errors++; $display("FAIL noend_no_emit got %b/%h exp 0/00", out_valid4, data_out4);
        end
        start4 = 1'b1;
      end
      if (k == 9) begin
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL noend_restart got %b exp 1", in_ready4); end
        start4 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    prog = P_SHR; start = 1'b1; in_valid = 1'b1; data_in = 8'h80; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0;
`ifdef FSM_SEQ_SAT_EN
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start got %b exp 0", sat_flag); end
`endif
      end
      if (k == 2) data_in = 8'h00;
      if (k == 3) in_valid = 1'b0;
      if (k == 4) begin
        checks++; if (dut.reg1 !== 8'h40) begin errors++; $display("FAIL shr1 got %h exp 40", dut.reg1); end
      end
      if (k == 5) begin
        checks++; if (dut.reg1 !== 8'h20) begin errors++; $display("FAIL shr2 got %h exp 20", dut.reg1); end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out got %h exp 00", data_out); end
    checks++; if (dut.reg1 !== 8'h00) begin errors++; $display("FAIL midrst_reg1 got %h exp 00", dut.reg1); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy4 got %b exp 0", busy4); end
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_backpressure();
    test_input_stall();
    test_no_end();
    test_wrap();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
